// File: rtl/mul_div_unit_if.sv
// Execute-stage port bundle of the HI/LO multiply/divide unit.
// The pipeline drives through the master modport; the unit uses the slave modport.
interface mul_div_unit_if;
  logic        issue_en;
  logic [1:0]  MULT;
  logic [1:0]  DIV;
  logic [1:0]  MFHL;
  logic [1:0]  MTHL;
  logic        flush;
  logic [31:0] rs_value;
  logic [31:0] rt_value;
  logic        busy;
  logic        stall;
  logic [31:0] hl_rdata;

  modport master (
    output issue_en, MULT, DIV, MFHL, MTHL, flush, rs_value, rt_value,
    input  busy, stall, hl_rdata
  );

  modport slave (
    input  issue_en, MULT, DIV, MFHL, MTHL, flush, rs_value, rt_value,
    output busy, stall, hl_rdata
  );
endinterface

// File: rtl/mul_div_unit.sv
// HI/LO multiply/divide unit: 32-cycle restoring divide and shift-add multiply on magnitudes.
// Define MDU_FAST_MULT_EN to make multiply a single-cycle combinational operation.
module mul_div_unit (
  input  logic          clk,
  input  logic          rst,
  mul_div_unit_if.slave bus
);
  typedef enum logic {IDLE, RUN} state_e;
  typedef enum logic [1:0] {OP_DIV, OP_DIVU, OP_MULT, OP_MULTU} op_e;

  state_e      state_q, state_d;
  op_e         op_q, op_d, op_sel;
  logic [4:0]  cnt_q, cnt_d;
  logic [31:0] hi_q, hi_d, lo_q, lo_d;
  logic [31:0] opnd_q, opnd_d;       // |divisor| for divide, |multiplicand| for multiply
  logic [31:0] acc_hi_q, acc_hi_d;   // partial remainder / upper product
  logic [31:0] acc_lo_q, acc_lo_d;   // dividend->quotient / multiplier->lower product
  logic        neg_q, neg_d, rem_neg_q, rem_neg_d;

  logic        any_div, any_mult, sel_signed, issue_ok, start, run_start, mthl_ok, is_div;
  logic [31:0] rs_abs, rt_abs, step_hi, step_lo;
  logic [32:0] trial, sum;
  logic [63:0] prod;
`ifdef MDU_FAST_MULT_EN
  logic [63:0] fast_prod;
`endif

  function automatic logic [31:0] abs32(input logic [31:0] v, input logic sgn);
    return (sgn && v[31]) ? (32'd0 - v) : v;
  endfunction

  always_comb begin
    any_div  = |bus.DIV;
    any_mult = |bus.MULT;
    if (bus.DIV[0])       op_sel = OP_DIV;
    else if (bus.DIV[1])  op_sel = OP_DIVU;
    else if (bus.MULT[0]) op_sel = OP_MULT;
    else                  op_sel = OP_MULTU;
  end

  assign sel_signed = (op_sel == OP_DIV) || (op_sel == OP_MULT);
  assign rs_abs     = abs32(bus.rs_value, sel_signed);
  assign rt_abs     = abs32(bus.rt_value, sel_signed);
  assign issue_ok   = bus.issue_en && !bus.flush && (state_q == IDLE);
  assign start      = issue_ok && (any_div || any_mult);
  assign mthl_ok    = issue_ok && !start;
  assign is_div     = (op_q == OP_DIV) || (op_q == OP_DIVU);

`ifdef MDU_FAST_MULT_EN
  assign run_start = issue_ok && any_div;
  assign fast_prod = {{32{sel_signed & bus.rs_value[31]}}, bus.rs_value}
                   * {{32{sel_signed & bus.rt_value[31]}}, bus.rt_value};
`else
  assign run_start = start;
`endif

  // One iteration: restoring-divide trial subtract, or shift-add multiply step.
  always_comb begin
    trial = {acc_hi_q, acc_lo_q[31]} - {1'b0, opnd_q};
    sum   = {1'b0, acc_hi_q} + (acc_lo_q[0] ? {1'b0, opnd_q} : 33'd0);
    if (is_div) begin
      if (!trial[32]) begin
        step_hi = trial[31:0];
        step_lo = {acc_lo_q[30:0], 1'b1};
      end else begin
        step_hi = {acc_hi_q[30:0], acc_lo_q[31]};
        step_lo = {acc_lo_q[30:0], 1'b0};
      end
    end else begin
      step_hi = sum[32:1];
      step_lo = {sum[0], acc_lo_q[31:1]};
    end
    prod = {step_hi, step_lo};
  end

  always_comb begin
    // NOTE: every _d takes its held value first so no path through this block infers a latch.
    state_d   = state_q;
    op_d      = op_q;
    cnt_d     = cnt_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    opnd_d    = opnd_q;
    acc_hi_d  = acc_hi_q;
    acc_lo_d  = acc_lo_q;
    neg_d     = neg_q;
    rem_neg_d = rem_neg_q;
    case (state_q)
      IDLE: begin
        if (run_start) begin
          state_d   = RUN;
          op_d      = op_sel;
          cnt_d     = 5'd0;
          neg_d     = sel_signed && (bus.rs_value[31] ^ bus.rt_value[31]);
          rem_neg_d = sel_signed && bus.rs_value[31];
          acc_hi_d  = 32'd0;
          acc_lo_d  = any_div ? rs_abs : rt_abs;
          opnd_d    = any_div ? rt_abs : rs_abs;
        end
`ifdef MDU_FAST_MULT_EN
        else if (start) begin
          {hi_d, lo_d} = fast_prod;
        end
`endif
        else if (mthl_ok) begin
          if (bus.MTHL[1]) hi_d = bus.rs_value;
          if (bus.MTHL[0]) lo_d = bus.rs_value;
        end
      end
      RUN: begin
        if (bus.flush) begin
          state_d = IDLE;
        end else begin
          acc_hi_d = step_hi;
          acc_lo_d = step_lo;
          cnt_d    = cnt_q + 5'd1;
          if (cnt_q == 5'd31) begin
            state_d = IDLE;
            if (is_div) begin
              // A zero divisor runs the full length but leaves HI/LO untouched.
              if (opnd_q != 32'd0) begin
                lo_d = neg_q     ? (32'd0 - step_lo) : step_lo;
                hi_d = rem_neg_q ? (32'd0 - step_hi) : step_hi;
              end
            end else begin
              {hi_d, lo_d} = neg_q ? (64'd0 - prod) : prod;
            end
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      op_q      <= OP_DIV;
      cnt_q     <= 5'd0;
      hi_q      <= 32'd0;
      lo_q      <= 32'd0;
      opnd_q    <= 32'd0;
      acc_hi_q  <= 32'd0;
      acc_lo_q  <= 32'd0;
      neg_q     <= 1'b0;
      rem_neg_q <= 1'b0;
    end else begin
      // NOTE: non-blocking updates so every flop samples the pre-edge value of the others.
      state_q   <= state_d;
      op_q      <= op_d;
      cnt_q     <= cnt_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      opnd_q    <= opnd_d;
      acc_hi_q  <= acc_hi_d;
      acc_lo_q  <= acc_lo_d;
      neg_q     <= neg_d;
      rem_neg_q <= rem_neg_d;
    end
  end

  assign bus.busy     = (state_q == RUN);
  assign bus.stall    = bus.busy && bus.issue_en && (|{bus.MULT, bus.DIV, bus.MFHL, bus.MTHL});
  assign bus.hl_rdata = bus.MFHL[1] ? hi_q : lo_q;
endmodule

// File: tb/tb_mul_div_unit.sv
// Scoreboard bench for mul_div_unit: expected reads and busy-pulse lengths are queued by
// the stimulus and popped by a negedge monitor when the unit presents them.
module tb_mul_div_unit;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  mul_div_unit_if bus ();
  mul_div_unit dut (.clk(clk), .rst(rst), .bus(bus));

  typedef struct {
    string       name;
    logic [31:0] value;
  } exp_t;

  exp_t exp_q[$];   // expected hl_rdata of each idle mfhi/mflo
  exp_t lat_q[$];   // expected length of each busy pulse
  int   n_checks = 0;
  int   n_fail   = 0;
  int   busy_len = 0;
  logic stall_seen;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, required 0x%08h", name, act, req);
    end
  endtask

  task automatic idle_inputs();
    bus.issue_en = 1'b0;
    bus.MULT     = 2'b00;
    bus.DIV      = 2'b00;
    bus.MFHL     = 2'b00;
    bus.MTHL     = 2'b00;
    bus.flush    = 1'b0;
    bus.rs_value = 32'd0;
    bus.rt_value = 32'd0;
  endtask

  // One issue_en cycle; returns 1 ns after the edge that consumed it.
  task automatic op(input logic [1:0] mult, input logic [1:0] div, input logic [1:0] mfhl,
                    input logic [1:0] mthl, input logic [31:0] a, input logic [31:0] b,
                    input logic fl);
    @(posedge clk); #1;
    bus.issue_en = 1'b1;
    bus.MULT     = mult;
    bus.DIV      = div;
    bus.MFHL     = mfhl;
    bus.MTHL     = mthl;
    bus.rs_value = a;
    bus.rt_value = b;
    bus.flush    = fl;
    #1 stall_seen = bus.stall;
    @(posedge clk); #1;
    idle_inputs();
  endtask

  task automatic read(input logic hi, input string name, input logic [31:0] v);
    exp_q.push_back('{name, v});
    op(2'b00, 2'b00, hi ? 2'b10 : 2'b01, 2'b00, 32'd0, 32'd0, 1'b0);
  endtask

  task automatic expect_busy(input string name, input logic [31:0] cycles);
    lat_q.push_back('{name, cycles});
  endtask

  task automatic expect_mult_busy(input string name);
`ifndef MDU_FAST_MULT_EN
    expect_busy(name, 32'd32);
`endif
  endtask

  task automatic wait_idle(input string name);
    int n = 0;
    while (bus.busy && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    check(name, {31'd0, bus.busy}, 32'd0);
  endtask

  task automatic read_pair(input string name, input logic [31:0] hi, input logic [31:0] lo);
    read(1'b1, {name, "_hi"}, hi);
    read(1'b0, {name, "_lo"}, lo);
  endtask

  always @(negedge clk) begin : monitor
    exp_t e;
    if (rst) begin
      busy_len = 0;
    end else begin
      if (bus.issue_en && (bus.MFHL != 2'b00) && !bus.busy && (exp_q.size() != 0)) begin
        e = exp_q.pop_front();
        check(e.name, bus.hl_rdata, e.value);
      end
      if (bus.busy) begin
        busy_len++;
      end else if (busy_len != 0) begin
        if (lat_q.size() != 0) begin
          e = lat_q.pop_front();
          check(e.name, 32'(busy_len), e.value);
        end else begin
          n_checks++;
          n_fail++;
          $display("FAIL busy_unexpected: got a %0d-cycle busy pulse, required none", busy_len);
        end
        busy_len = 0;
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL global_timeout: simulation still running at %0t", $time);
    $fatal(1, "timeout");
  end

  initial begin
    idle_inputs();
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    check("rst_busy", {31'd0, bus.busy}, 32'd0);
    read_pair("rst", 32'd0, 32'd0);
    check("idle_mflo_no_stall", {31'd0, stall_seen}, 32'd0);

    expect_busy("div_busy", 32'd32);
    op(2'b00, 2'b01, 2'b00, 2'b00, 32'd100, 32'd7, 1'b0);
    wait_idle("div_done");
    bus.MFHL = 2'b01;
    #1 check("div_lo_first_idle_cycle", bus.hl_rdata, 32'd14);
    bus.MFHL = 2'b00;
    read_pair("div_100_7", 32'd2, 32'd14);

    expect_busy("sdiv_busy", 32'd32);
    op(2'b00, 2'b01, 2'b00, 2'b00, 32'hFFFF_FF9C, 32'd7, 1'b0);
    wait_idle("sdiv_done");
    read_pair("div_m100_7", 32'hFFFF_FFFE, 32'hFFFF_FFF2);

    // 4294967196 = 7 * 613566742 + 2
    expect_busy("divu_busy", 32'd32);
    op(2'b00, 2'b10, 2'b00, 2'b00, 32'hFFFF_FF9C, 32'd7, 1'b0);
    wait_idle("divu_done");
    read_pair("divu_m100_7", 32'h0000_0002, 32'h2492_4916);

    expect_busy("div_negb_busy", 32'd32);
    op(2'b00, 2'b01, 2'b00, 2'b00, 32'd100, 32'hFFFF_FFF9, 1'b0);
    wait_idle("div_negb_done");
    read_pair("div_100_m7", 32'd2, 32'hFFFF_FFF2);

    expect_mult_busy("mult_busy");
    op(2'b01, 2'b00, 2'b00, 2'b00, 32'hFFFF_FFFF, 32'd2, 1'b0);
`ifdef MDU_FAST_MULT_EN
    check("fast_mult_no_busy", {31'd0, bus.busy}, 32'd0);
    bus.MFHL = 2'b10;
    #1 check("fast_mult_hi_next_cycle", bus.hl_rdata, 32'hFFFF_FFFF);
    bus.MFHL = 2'b00;
`endif
    wait_idle("mult_done");
    read_pair("mult_m1_2", 32'hFFFF_FFFF, 32'hFFFF_FFFE);

    expect_mult_busy("multu_busy");
    op(2'b10, 2'b00, 2'b00, 2'b00, 32'hFFFF_FFFF, 32'd2, 1'b0);
    wait_idle("multu_done");
    read_pair("multu_ffffffff_2", 32'h0000_0001, 32'hFFFF_FFFE);

    expect_mult_busy("mult_negneg_busy");
    op(2'b01, 2'b00, 2'b00, 2'b00, 32'hFFFF_FFFD, 32'hFFFF_FFFB, 1'b0);
    wait_idle("mult_negneg_done");
    read_pair("mult_m3_m5", 32'd0, 32'd15);

    // Priority: DIV[0] > DIV[1] > MULT[0] > MULT[1]
    expect_busy("prio_all_busy", 32'd32);
    op(2'b11, 2'b11, 2'b00, 2'b00, 32'hFFFF_FF9C, 32'd7, 1'b0);
    wait_idle("prio_all_done");
    read_pair("prio_div", 32'hFFFF_FFFE, 32'hFFFF_FFF2);
    expect_busy("prio_divu_busy", 32'd32);
    op(2'b11, 2'b10, 2'b00, 2'b00, 32'hFFFF_FF9C, 32'd7, 1'b0);
    wait_idle("prio_divu_done");
    read_pair("prio_divu", 32'h0000_0002, 32'h2492_4916);
    expect_mult_busy("prio_mult_busy");
    op(2'b11, 2'b00, 2'b00, 2'b00, 32'hFFFF_FFFF, 32'd2, 1'b0);
    wait_idle("prio_mult_done");
    read_pair("prio_mult", 32'hFFFF_FFFF, 32'hFFFF_FFFE);

    op(2'b00, 2'b00, 2'b00, 2'b10, 32'h1234_5678, 32'd0, 1'b0);
    op(2'b00, 2'b00, 2'b00, 2'b01, 32'hCAFE_BABE, 32'd0, 1'b0);
    expect_busy("divu_zero_busy", 32'd32);
    op(2'b00, 2'b10, 2'b00, 2'b00, 32'd55, 32'd0, 1'b0);
    op(2'b00, 2'b00, 2'b10, 2'b00, 32'd0, 32'd0, 1'b0);
    check("mfhi_busy_stall", {31'd0, stall_seen}, 32'd1);
    op(2'b00, 2'b00, 2'b00, 2'b01, 32'hDEAD_BEEF, 32'd0, 1'b0);
    check("mtlo_busy_stall", {31'd0, stall_seen}, 32'd1);
    wait_idle("divu_zero_done");
    read_pair("div_by_zero_kept", 32'h1234_5678, 32'hCAFE_BABE);

    expect_busy("mthl_start_busy", 32'd32);
    op(2'b00, 2'b10, 2'b00, 2'b10, 32'd100, 32'd7, 1'b0);
    wait_idle("mthl_start_done");
    read_pair("start_beats_mthi", 32'd2, 32'd14);

    op(2'b00, 2'b00, 2'b00, 2'b11, 32'h1111_1111, 32'd0, 1'b0);
    op(2'b00, 2'b00, 2'b00, 2'b01, 32'h2222_2222, 32'd0, 1'b0);
    read_pair("mthl_both", 32'h1111_1111, 32'h2222_2222);

    // Flush in IDLE blocks both a start and an MTHL write (no busy pulse is queued).
    op(2'b00, 2'b01, 2'b00, 2'b01, 32'h3333_3333, 32'd7, 1'b1);
    check("flush_idle_no_start", {31'd0, bus.busy}, 32'd0);
    read_pair("flush_idle", 32'h1111_1111, 32'h2222_2222);

    expect_busy("flush_cnt10_busy", 32'd11);
    op(2'b00, 2'b01, 2'b00, 2'b00, 32'd1000, 32'd3, 1'b0);
    repeat (10) begin @(posedge clk); #1; end
    bus.flush = 1'b1;
    @(posedge clk); #1;
    bus.flush = 1'b0;
    check("flush_cnt10_idle", {31'd0, bus.busy}, 32'd0);
    read_pair("flush_cnt10", 32'h1111_1111, 32'h2222_2222);

    expect_busy("flush_cnt31_busy", 32'd32);
    op(2'b00, 2'b01, 2'b00, 2'b00, 32'd1000, 32'd3, 1'b0);
    repeat (31) begin @(posedge clk); #1; end
    bus.flush = 1'b1;
    @(posedge clk); #1;
    bus.flush = 1'b0;
    check("flush_cnt31_idle", {31'd0, bus.busy}, 32'd0);
    read_pair("flush_cnt31", 32'h1111_1111, 32'h2222_2222);

    op(2'b00, 2'b01, 2'b00, 2'b00, 32'd1000, 32'd3, 1'b0);
    repeat (20) begin @(posedge clk); #1; end
    #2 rst = 1'b1;
    #1 check("rst_mid_run_busy", {31'd0, bus.busy}, 32'd0);
    bus.MFHL = 2'b10;
    #1 check("rst_mid_run_hi", bus.hl_rdata, 32'd0);
    bus.MFHL = 2'b01;
    #1 check("rst_mid_run_lo", bus.hl_rdata, 32'd0);
    bus.MFHL = 2'b00;
    #2 rst = 1'b0;
    repeat (3) @(posedge clk);
    #1 check("post_rst_busy", {31'd0, bus.busy}, 32'd0);
    read_pair("post_rst", 32'd0, 32'd0);

    repeat (3) @(posedge clk);
    check("sb_reads_drained", 32'(exp_q.size()), 32'd0);
    check("sb_busy_drained", 32'(lat_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
